// File: rtl/mcs4.sv
// Shared MCS-4 types: 4-bit bus character and the I/O-RAM opcode group (OPA field).
package mcs4;

    localparam int unsigned CHAR_W = 4;

    typedef logic [CHAR_W-1:0] char_t;

    typedef enum logic [CHAR_W-1:0] {
        OPA_WRM = 4'h0, OPA_WMP = 4'h1, OPA_WRR = 4'h2, OPA_WPM = 4'h3,
        OPA_WR0 = 4'h4, OPA_WR1 = 4'h5, OPA_WR2 = 4'h6, OPA_WR3 = 4'h7,
        OPA_SBM = 4'h8, OPA_RDM = 4'h9, OPA_RDR = 4'hA, OPA_ADM = 4'hB,
        OPA_RD0 = 4'hC, OPA_RD1 = 4'hD, OPA_RD2 = 4'hE, OPA_RD3 = 4'hF
    } ioram_opa_t;

    // Opcodes whose IO frame carries host data on the bus at X2.
    function automatic logic opa_is_write(input char_t opa);
        case (ioram_opa_t'(opa))
            OPA_WRM, OPA_WMP, OPA_WR0, OPA_WR1, OPA_WR2, OPA_WR3: return 1'b1;
            default:                                              return 1'b0;
        endcase
    endfunction

    // Opcodes whose IO frame returns RAM data on the bus at X2.
    function automatic logic opa_is_read(input char_t opa);
        case (ioram_opa_t'(opa))
            OPA_SBM, OPA_RDM, OPA_ADM, OPA_RD0, OPA_RD1, OPA_RD2, OPA_RD3: return 1'b1;
            default:                                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/i4002_host_seq.sv
// Host-side MCS-4 I/O-RAM sequencer: turns single host requests into SRC/IO bus
// frames for attached i4002 RAMs and returns one response per request.
module i4002_host_seq #(
    parameter bit SRC_CACHE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  mcs4::char_t req_opa,
    input  logic [7:0]  req_addr,
    input  mcs4::char_t req_wdata,
    output logic        rsp_valid,
    output mcs4::char_t rsp_data,
    output logic        sync,
    output logic        cm_ram,
    output mcs4::char_t dbus_out,
    input  mcs4::char_t dbus_in
);

    localparam int unsigned PH_W   = 3;
    localparam int unsigned ADDR_W = 8;

    localparam logic [PH_W-1:0] PH_M2 = PH_W'(4);
    localparam logic [PH_W-1:0] PH_X2 = PH_W'(6);
    localparam logic [PH_W-1:0] PH_X3 = PH_W'(7);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SRC,
        ST_IO
    } state_t;

    logic [PH_W-1:0]   phase;
    state_t            state;
    logic              cache_valid;
    logic [ADDR_W-1:0] cache_addr;
    logic [ADDR_W-1:0] addr_q;
    mcs4::char_t       opa_q;
    mcs4::char_t       wdata_q;

    logic [PH_W-1:0] phase_nxt;
    logic            accept;
    logic            hit;

    assign phase_nxt = phase + PH_W'(1);
    assign accept    = req_valid && req_ready;
    assign hit       = SRC_CACHE && cache_valid && (req_addr == cache_addr);

    // Frame FSM, phase counter and all bus/handshake outputs; outputs are set one
    // clock ahead from phase_nxt so they line up with the phase they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase       <= PH_X3;
            state       <= ST_IDLE;
            cache_valid <= 1'b0;
            cache_addr  <= '0;
            addr_q      <= '0;
            opa_q       <= '0;
            wdata_q     <= '0;
            sync        <= 1'b1;
            req_ready   <= 1'b1;
            cm_ram      <= 1'b0;
            dbus_out    <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
        end else begin
            phase     <= phase_nxt;
            sync      <= (phase_nxt == PH_X3);
            req_ready <= (phase_nxt == PH_X3) && (state != ST_SRC);
            cm_ram    <= 1'b0;
            dbus_out  <= '0;
            rsp_valid <= 1'b0;

            // Frame boundary: state may only change on the X3->A1 edge.
            if (phase == PH_X3) begin
                if (accept) begin
                    opa_q   <= req_opa;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    state   <= hit ? ST_IO : ST_SRC;
                end else if (state == ST_SRC) begin
                    state <= ST_IO;
                end else begin
                    state <= ST_IDLE;
                end
                if (state == ST_SRC) begin
                    cache_valid <= 1'b1;
                    cache_addr  <= addr_q;
                end
            end

            case (state)
                ST_SRC: begin
                    if (phase_nxt == PH_X2) begin
                        cm_ram   <= 1'b1;
                        dbus_out <= addr_q[3:0];
                    end else if (phase_nxt == PH_X3) begin
                        dbus_out <= addr_q[7:4];
                    end
                end
                ST_IO: begin
                    if (phase_nxt == PH_M2) begin
                        cm_ram   <= 1'b1;
                        dbus_out <= opa_q;
                    end else if ((phase_nxt == PH_X2) && mcs4::opa_is_write(opa_q)) begin
                        dbus_out <= wdata_q;
                    end
                    // Read data is captured on the edge that closes X2.
                    if (phase == PH_X2) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= mcs4::opa_is_read(opa_q) ? dbus_in : '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
